// File: rtl/blit_text_expand_pkg.sv
// Shared blitter definitions: expander FSM states and the font/glyph geometry.
package blit_text_expand_pkg;

  localparam int FONT_ROW_BITS  = 32;
  localparam int GLYPH_DIM_BITS = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/blit_text_expand_if.sv
// Command, font-row and pixel handshake bundle for the glyph expander.
interface blit_text_expand_if
  import blit_text_expand_pkg::*;
#(
  parameter int COLOUR_BITS = 8
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [GLYPH_DIM_BITS-1:0] cmd_wm1;
  logic [GLYPH_DIM_BITS-1:0] cmd_hm1;
  logic [COLOUR_BITS-1:0]    cmd_fg;
  logic [COLOUR_BITS-1:0]    cmd_bg;
  logic                      cmd_transparent;

  logic                      font_valid;
  logic                      font_ready;
  logic [FONT_ROW_BITS-1:0]  font_data;

  logic                      pix_valid;
  logic                      pix_ready;
  logic [GLYPH_DIM_BITS-1:0] pix_x;
  logic [GLYPH_DIM_BITS-1:0] pix_y;
  logic [COLOUR_BITS-1:0]    pix_colour;
  logic                      pix_we;
  logic                      pix_last;
  logic                      done;

  // Upstream command/font source and downstream pixel sink.
  modport master (
    output cmd_valid, cmd_wm1, cmd_hm1, cmd_fg, cmd_bg, cmd_transparent,
    output font_valid, font_data, pix_ready,
    input  cmd_ready, font_ready,
    input  pix_valid, pix_x, pix_y, pix_colour, pix_we, pix_last, done
  );

  // The expander itself.
  modport slave (
    input  cmd_valid, cmd_wm1, cmd_hm1, cmd_fg, cmd_bg, cmd_transparent,
    input  font_valid, font_data, pix_ready,
    output cmd_ready, font_ready,
    output pix_valid, pix_x, pix_y, pix_colour, pix_we, pix_last, done
  );

endinterface

// File: rtl/blit_text_expand.sv
// Glyph expander: turns 1-bpp font rows (MSB = x0) into per-pixel colour writes.
module blit_text_expand
  import blit_text_expand_pkg::*;
#(
  parameter int COLOUR_BITS = 8
)
(
  input logic               clock,
  input logic               reset,
  blit_text_expand_if.slave bus
);

  state_e                    state_q;
  logic [GLYPH_DIM_BITS-1:0] x_q;
  logic [GLYPH_DIM_BITS-1:0] y_q;
  logic [GLYPH_DIM_BITS-1:0] wm1_q;
  logic [GLYPH_DIM_BITS-1:0] hm1_q;
  logic [FONT_ROW_BITS-1:0]  shreg_q;
  logic [COLOUR_BITS-1:0]    fg_q;
  logic [COLOUR_BITS-1:0]    bg_q;
  logic                      transp_q;
  logic                      done_q;

  logic emitting;
  logic at_row_end;
  logic at_glyph_end;
  logic cur_bit;

  assign emitting     = (state_q == EMIT);
  assign at_row_end   = (x_q == wm1_q);
  assign at_glyph_end = at_row_end && (y_q == hm1_q);
  assign cur_bit      = shreg_q[FONT_ROW_BITS-1];

  // Glyph sequencer: latch command, fetch one row, shift it out pixel by pixel.
  // Geometry/colour/shift data carry no reset; every output that uses them is
  // gated by the EMIT state, which is only reachable after a fresh latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            wm1_q    <= bus.cmd_wm1;
            hm1_q    <= bus.cmd_hm1;
            fg_q     <= bus.cmd_fg;
            bg_q     <= bus.cmd_bg;
            transp_q <= bus.cmd_transparent;
            x_q      <= '0;
            y_q      <= '0;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          if (bus.font_valid) begin
            shreg_q <= bus.font_data;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (bus.pix_ready) begin
            if (!at_row_end) begin
              shreg_q <= {shreg_q[FONT_ROW_BITS-2:0], 1'b0};
              x_q     <= x_q + GLYPH_DIM_BITS'(1);
            end else if (!at_glyph_end) begin
              x_q     <= '0;
              y_q     <= y_q + GLYPH_DIM_BITS'(1);
              state_q <= FETCH;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state registers; no input-to-output paths.
  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.font_ready = (state_q == FETCH);
  assign bus.pix_valid  = emitting;
  assign bus.pix_x      = x_q;
  assign bus.pix_y      = y_q;
  assign bus.pix_colour = emitting ? (cur_bit ? fg_q : bg_q) : '0;
  assign bus.pix_we     = emitting && (cur_bit || !transp_q);
  assign bus.pix_last   = emitting && at_glyph_end;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_blit_text_expand.sv
// Directed bench for blit_text_expand with a queue-based pixel model.
module tb_blit_text_expand;

  localparam int CB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  blit_text_expand_if #(.COLOUR_BITS(CB)) bus();

  blit_text_expand #(.COLOUR_BITS(CB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]    x;
    logic [4:0]    y;
    logic [CB-1:0] c;
    logic          we;
    logic          last;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        mon_e;
  logic [31:0] rows_a [32];
  int          n_vec = 0;
  int          n_err = 0;
  int          font_hs = 0;
  int          acc_cnt = 0;
  bit          last_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected pixel stream straight from the glyph rules: row y, bit 31-x.
  task automatic build(input int w, input int h, input logic [CB-1:0] fg,
                       input logic [CB-1:0] bg, input logic tr);
    pix_t p;
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        logic [31:0] row;
        logic        b;
        row    = rows_a[y];
        b      = row[31-x];
        p.x    = 5'(x);
        p.y    = 5'(y);
        p.c    = b ? fg : bg;
        p.we   = b | ~tr;
        p.last = (x == w-1) && (y == h-1);
        exp_q.push_back(p);
      end
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      last_prev = 1'b0;
    end else begin
      check("done", 32'(bus.done), 32'(last_prev));
      if (last_prev) check("cmd_ready_after_done", 32'(bus.cmd_ready), 32'd1);
      check("font_ready_exclusive", 32'(bus.font_ready && (bus.pix_valid || bus.cmd_ready)), 32'd0);
      if (bus.font_valid && bus.font_ready) font_hs++;
      if (bus.pix_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q[0];
          check("pix_x", 32'(bus.pix_x), 32'(mon_e.x));
          check("pix_y", 32'(bus.pix_y), 32'(mon_e.y));
          check("pix_colour", 32'(bus.pix_colour), 32'(mon_e.c));
          check("pix_we", 32'(bus.pix_we), 32'(mon_e.we));
          check("pix_last", 32'(bus.pix_last), 32'(mon_e.last));
          if (bus.pix_ready) begin
            mon_e = exp_q.pop_front();
            acc_cnt++;
          end
        end
      end
      last_prev = bus.pix_valid && bus.pix_ready && bus.pix_last;
    end
  end

  // One glyph: issue command, feed rows, drive pix_ready, optionally abort at (3,1).
  task automatic run_glyph(input int w, input int h, input logic [CB-1:0] fg,
                           input logic [CB-1:0] bg, input logic tr,
                           input bit rmode, input bit hold, input bit abort);
    int row_idx;
    bit hs;
    bit fin;
    row_idx = 0;
    fin     = 1'b0;
    build(w, h, fg, bg, tr);
    bus.font_valid = hold;
    bus.font_data  = rows_a[0];
    if (hold) begin
      repeat (3) @(posedge clock);
      #1;
    end
    font_hs = 0;
    acc_cnt = 0;
    bus.cmd_wm1         = 5'(w-1);
    bus.cmd_hm1         = 5'(h-1);
    bus.cmd_fg          = fg;
    bus.cmd_bg          = bg;
    bus.cmd_transparent = tr;
    bus.cmd_valid       = 1'b1;
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    check("font_ready_after_cmd", 32'(bus.font_ready), 32'd1);
    check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (bus.done) begin
        fin = 1'b1;
        break;
      end
      if (abort && bus.pix_valid && bus.pix_x == 5'd3 && bus.pix_y == 5'd1) begin
        fin = 1'b1;
        break;
      end
      bus.font_valid = hold ? 1'b1 : (bus.font_ready && row_idx < h);
      bus.font_data  = rows_a[row_idx > 31 ? 31 : row_idx];
      bus.pix_ready  = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      hs = bus.font_valid && bus.font_ready;
      @(posedge clock);
      #1;
      if (hs) row_idx++;
    end
    bus.pix_ready  = 1'b0;
    bus.font_valid = hold;
    if (!fin) check("glyph_timeout", 32'd0, 32'd1);
    if (abort) begin
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_pix_valid", 32'(bus.pix_valid), 32'd0);
      check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("abort_font_ready", 32'(bus.font_ready), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      exp_q.delete();
    end else begin
      check("leftover_pixels", 32'(exp_q.size()), 32'd0);
      check("font_handshakes", 32'(font_hs), 32'(h));
      check("accepted_pixels", 32'(acc_cnt), 32'(w*h));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CB-1:0] lit_c [8];
    logic [7:0]    we_pat;
    bus.cmd_valid       = 1'b0;
    bus.cmd_wm1         = '0;
    bus.cmd_hm1         = '0;
    bus.cmd_fg          = '0;
    bus.cmd_bg          = '0;
    bus.cmd_transparent = 1'b0;
    bus.font_valid      = 1'b0;
    bus.font_data       = '0;
    bus.pix_ready       = 1'b0;
    for (int i = 0; i < 32; i++) rows_a[i] = '0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_font_ready", 32'(bus.font_ready), 32'd0);
    check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    check("rst_pix_we", 32'(bus.pix_we), 32'd0);
    check("rst_pix_last", 32'(bus.pix_last), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_pix_x", 32'(bus.pix_x), 32'd0);
    check("rst_pix_y", 32'(bus.pix_y), 32'd0);
    check("rst_pix_colour", 32'(bus.pix_colour), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Pin the model on the hand-worked 8x1 glyph, row 0xA5000000.
    rows_a[0] = 32'hA500_0000;
    lit_c = '{8'h0F, 8'h01, 8'h0F, 8'h01, 8'h01, 8'h0F, 8'h01, 8'h0F};
    build(8, 1, 8'h0F, 8'h01, 1'b0);
    for (int i = 0; i < 8; i++) check("model_colour", 32'(exp_q[i].c), 32'(lit_c[i]));
    check("model_last7", 32'(exp_q[7].last), 32'd1);
    check("model_last6", 32'(exp_q[6].last), 32'd0);
    we_pat = 8'b1010_0101;
    build(8, 1, 8'h0F, 8'h01, 1'b1);
    for (int i = 0; i < 8; i++) check("model_we", 32'(exp_q[i].we), 32'(we_pat[7-i]));
    exp_q.delete();

    // 8x1 opaque, then transparent.
    run_glyph(8, 1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_glyph(8, 1, 8'h0F, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Full 32x32 glyph, no backpressure.
    for (int i = 0; i < 32; i++) rows_a[i] = $urandom;
    run_glyph(32, 32, 8'hC3, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5x3 with random backpressure; low row bits are junk that must be ignored.
    rows_a[0] = 32'hA800_FFFF;
    rows_a[1] = 32'h5000_1234;
    rows_a[2] = 32'hF87F_FFFF;
    run_glyph(5, 3, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);

    // font_valid held high throughout, including IDLE and EMIT.
    rows_a[0] = 32'h9000_0000;
    rows_a[1] = 32'h6000_0000;
    run_glyph(4, 2, 8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-glyph at (3,1), then a fresh glyph from (0,0).
    for (int i = 0; i < 4; i++) rows_a[i] = 32'h0F00_0000 ^ (32'h1100_0000 << i);
    run_glyph(8, 4, 8'h77, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1);
    run_glyph(8, 4, 8'h77, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blit_text_expand.md
# blit_text_expand

Glyph expander for the blitter text path. It accepts one glyph command and then consumes font rows, one 32-bit word per row, fetched from the glyph source address computed upstream. It expands each 1-bpp row MSB-first into a stream of per-pixel colour writes toward the blitter destination stage. It sits between the font-memory read response and the destination pixel writer.

## Interface
Parameters:
- COLOUR_BITS, 8, width of the fg/bg colour and of the output pixel colour

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  glyph command present
- cmd_ready  out  1  block idle and able to accept a command
- cmd_wm1  in  5  glyph width minus 1 (1..32 px)
- cmd_hm1  in  5  glyph height minus 1 (1..32 rows)
- cmd_fg  in  COLOUR_BITS  colour for set bits
- cmd_bg  in  COLOUR_BITS  colour for clear bits
- cmd_transparent  in  1  clear bits produce no write
- font_valid  in  1  font row word present
- font_ready  out  1  block waiting for a row
- font_data  in  32  row bits; bit 31 is pixel x=0
- pix_valid  out  1  pixel present
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  5  column within glyph
- pix_y  out  5  row within glyph
- pix_colour  out  COLOUR_BITS  fg or bg
- pix_we  out  1  0 for a transparent clear pixel; the slot is still emitted so downstream address stepping stays aligned
- pix_last  out  1  last pixel of the glyph
- done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, FETCH, EMIT.
- IDLE: cmd_ready=1. On cmd_valid, latch wm1, hm1, fg, bg and transparent; set x=0 and y=0; go to FETCH.
- FETCH: font_ready=1. On font_valid, load the 32-bit shift register from font_data and go to EMIT.
- EMIT: pix_valid=1.
  - Pixel outputs: pix_colour = shreg[31] ? fg : bg; pix_we = shreg[31] | ~transparent; pix_last = (x==wm1 && y==hm1).
  - On pix_ready with x!=wm1: shift the register left by 1 and increment x.
  - On pix_ready with x==wm1 and y!=hm1: set x=0, increment y, go to FETCH.
  - On pix_ready with x==wm1 and y==hm1: go to IDLE and pulse done.
- Bits beyond wm1 in each row word are ignored.
- Handshakes are standard valid/ready. A transfer occurs only on a cycle with valid&&ready. pix_* outputs hold stable while pix_valid && !pix_ready.
- cmd_ready=0 outside IDLE. font_ready=0 outside FETCH. Font words presented early are not consumed.
- x and y never wrap, because they stop at wm1 and hm1 (both ≤31).

## Timing
- Reset: state IDLE, cmd_ready=1, font_ready=0, pix_valid=0, pix_we=0, pix_last=0, done=0, pix_x=0, pix_y=0, pix_colour=0.
- Reset asserted mid-glyph aborts the glyph. On the next cycle the reset values apply. No done pulse is generated. Any partially emitted glyph is discarded.
- Command accepted in cycle N: font_ready=1 in N+1.
- Row accepted in cycle M: pix_valid=1 with x=0 in M+1.
- Throughput is 1 pixel/cycle within a row. Each row boundary costs at least one FETCH cycle.
- Last-pixel accept in cycle L: done=1 and cmd_ready=1 in L+1. A new command may be accepted in L+1.
- All outputs are registered or decoded directly from state registers. There is no combinational path from any *_valid or pix_ready input to any output.

## Structure
- Shared blitter package holds the FSM state enum {IDLE, FETCH, EMIT} and the constants FONT_ROW_BITS=32 and GLYPH_DIM_BITS=5.
- Single module. The 32-bit shift register and the x/y counters are simple enough to keep inline; no sub-module.

## Test plan
- 8x1 glyph, fg=0x0F, bg=0x01, opaque, row 0xA5000000 -> colours 0F,01,0F,01,01,0F,01,0F; pix_we all 1; pix_last only on x=7; done one cycle later.
- Same glyph with transparent=1 -> 8 pixels emitted; pix_we pattern 1,0,1,0,0,1,0,1.
- 32x32 glyph, pix_ready held 1, font word offered the cycle font_ready rises -> 1024 pixels; x wraps 31→0 with y increment; exactly 32 font handshakes; pix_last at (31,31).
- Random pix_ready backpressure on a 5x3 glyph -> pix_x, pix_y and pix_colour stable while stalled; no pixel lost or duplicated; 15 accepted transfers.
- font_valid held high while in IDLE or EMIT -> no word consumed, because font_ready is low in both states.
- Reset asserted at pixel (3,1) of a 8x4 glyph -> next cycle pix_valid=0, cmd_ready=1, done=0; a fresh command then starts at (0,0).
